// File: rtl/uart_lock_status_tx.sv
// UART 8N1 status reporter: sends the lock state char ('O'/'C') followed by LF
// whenever lock_open changes from the last reported level or a report is requested.
module uart_lock_status_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_open,
    input  logic report_req,
    output logic tx_pin,
    output logic busy
);
    // CLKS_PER_BIT must be at least 2 for the cycle counter to exist.
    localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int              CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_LAST     = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_q, byte_d;
    logic            snap_q, snap_d;
    logic            rep_q, rep_d;
    logic            pend_q, pend_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            launch;
    logic [7:0]      cur_byte;

    assign cur_byte = byte_q ? 8'h0A : (snap_q ? 8'h4F : 8'h43);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        rep_d   = rep_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((lock_open != rep_q) || pend_q) begin
                    launch  = 1'b1;
                    snap_d  = lock_open;
                    rep_d   = lock_open;
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    byte_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Byte1 start bit follows byte0 stop bit with no gap.
                    if (!byte_q) begin
                        byte_d  = 1'b1;
                        state_d = START;
                    end else begin
                        byte_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request arriving with a launch is covered by that launch.
        pend_d = launch ? 1'b0 : (pend_q | report_req);
        busy_d = (state_d != IDLE);

        // Line level lags the state by one cycle, giving the launch latency.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            snap_q  <= 1'b0;
            rep_q   <= 1'b0;
            pend_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            rep_q   <= rep_d;
            pend_q  <= pend_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_pin = tx_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_uart_lock_status_tx.sv
// Directed bench for uart_lock_status_tx at CLKS_PER_BIT=10: decodes frames
// off tx_pin and compares against hand-computed bytes and timings.
module tb_uart_lock_status_tx;
    logic clk = 1'b0;
    logic rst, lock_open, report_req;
    logic tx_pin, busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   s1, s2, k;

    uart_lock_status_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk(clk), .rst(rst), .lock_open(lock_open), .report_req(report_req),
        .tx_pin(tx_pin), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Waits for a start bit, then samples every bit mid-cell and counts busy cycles.
    task automatic rx_msg(input string tag, input logic [7:0] e0, output int st);
        int n, bcnt, ferr, off, slot;
        logic pb, found;
        logic [7:0] b0, b1;
        pb = busy; n = 0; st = -1; found = 1'b0;
        b0 = 8'h00; b1 = 8'h00;
        while (!found) begin
            @(negedge clk);
            if (tx_pin == 1'b0) found = 1'b1;
            else begin
                pb = busy;
                n++;
                if (n > 1000) begin
                    check({tag, "_timeout"}, 0, 1);
                    return;
                end
            end
        end
        st = cyc; bcnt = int'(pb); ferr = 0;
        for (int t = 0; t < 200; t++) begin
            if (t > 0) @(negedge clk);
            bcnt += int'(busy);
            off = t % 100;
            if (off % 10 == 5) begin
                slot = off / 10;
                if (slot == 0)      ferr += int'(tx_pin != 1'b0);
                else if (slot == 9) ferr += int'(tx_pin != 1'b1);
                else if (t < 100)   b0[slot-1] = tx_pin;
                else                b1[slot-1] = tx_pin;
            end
        end
        check({tag, "_byte0"}, int'(b0), int'(e0));
        check({tag, "_byte1"}, int'(b1), 32'h0A);
        check({tag, "_framing"}, ferr, 0);
        check({tag, "_busy_len"}, bcnt, 200);
    endtask

    task automatic quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            bad += int'((tx_pin == 1'b0) || busy);
        end
        check(tag, bad, 0);
    endtask

    task automatic pulse_req();
        report_req = 1'b1;
        @(negedge clk);
        report_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; lock_open = 1'b0; report_req = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx_pin), 1);
        check("reset_busy", int'(busy), 0);
        rst = 1'b1;
        quiet("idle_after_reset", 500);

        // Open: launch at edge k, line low from k+1.
        @(negedge clk); lock_open = 1'b1; k = cyc + 1;
        @(negedge clk);
        check("launch_tx_still_high", int'(tx_pin), 1);
        check("launch_busy", int'(busy), 1);
        rx_msg("open", 8'h4F, s1);
        check("launch_latency", s1 - k, 1);

        // Close, then reopen mid-message: second message 201 cycles after first.
        @(negedge clk); lock_open = 1'b0;
        fork
            begin rx_msg("close", 8'h43, s1); rx_msg("reopen", 8'h4F, s2); end
            begin repeat (80) @(negedge clk); lock_open = 1'b1; end
        join
        check("back_to_back_gap", s2 - s1, 201);

        // Even toggles mid-message coalesce into nothing.
        @(negedge clk); lock_open = 1'b0;
        rx_msg("close2", 8'h43, s1);
        @(negedge clk); lock_open = 1'b1;
        fork
            rx_msg("coalesce", 8'h4F, s1);
            begin
                repeat (50) @(negedge clk); lock_open = 1'b0;
                repeat (50) @(negedge clk); lock_open = 1'b1;
            end
        join
        quiet("coalesce_no_second", 300);

        // Report requests: idle, one during busy, two during busy.
        @(negedge clk); lock_open = 1'b0;
        rx_msg("close3", 8'h43, s1);
        @(negedge clk);
        pulse_req();
        fork
            begin
                rx_msg("req_idle", 8'h43, s1);
                rx_msg("req_busy1", 8'h43, s1);
                rx_msg("req_busy2", 8'h43, s1);
            end
            begin
                repeat (50) @(negedge clk); pulse_req();
                repeat (250) @(negedge clk); pulse_req();
                repeat (30) @(negedge clk); pulse_req();
            end
        join
        quiet("req_no_extra", 300);

        // Reset mid byte0 (bit 5 of 'O' is 0), then a clean full message.
        @(negedge clk); lock_open = 1'b1;
        repeat (62) @(negedge clk);
        check("bit5_low", int'(tx_pin), 0);
        rst = 1'b0;
        #1;
        check("async_reset_tx", int'(tx_pin), 1);
        check("async_reset_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        check("held_reset_tx", int'(tx_pin), 1);
        rst = 1'b1;
        rx_msg("post_reset", 8'h4F, s1);
        quiet("post_reset_quiet", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
